// File: rtl/dot_product_sequencer.sv
// Sequential N-element dot product: operand vectors written via WR/Dir, one MAC per clock after Start.
// Build option: define DOT_SAT_EN to saturate Data_Out and raise Ovf instead of wrapping.
//
// state | meaning
// IDLE  | waiting for Start; writes accepted
// MAC   | accumulating Vector1[idx]*Vector2[idx]; writes rejected with Wr_Ign
// DONE  | publishing acc to Data_Out with a Done pulse; writes accepted
module dot_product_sequencer #(
  parameter  int DATA_W = 8,
  parameter  int N_ELEM = 4,
  parameter  int OUT_W  = 16,
  localparam int ADDR_W = $clog2(N_ELEM),
  localparam int ACC_W  = 2*DATA_W + $clog2(N_ELEM)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] Data_In1,
  input  logic [DATA_W-1:0] Data_In2,
  input  logic [ADDR_W-1:0] Dir,
  input  logic              WR,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic              Wr_Ign,
  output logic              Ovf,
  output logic [OUT_W-1:0]  Data_Out
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ELEM - 1);

  state_t              state, state_n;
  logic [ACC_W-1:0]    acc, acc_n;
  logic [ADDR_W-1:0]   idx, idx_n;
  logic [DATA_W-1:0]   vec1 [N_ELEM];
  logic [DATA_W-1:0]   vec2 [N_ELEM];
  logic [2*DATA_W-1:0] prod;
  logic [OUT_W-1:0]    result_n;
  logic [OUT_W-1:0]    data_out_q;
  logic                done_q;
  logic                wr_ign_q;
  logic                wr_en;

  assign prod  = {{DATA_W{1'b0}}, vec1[idx]} * {{DATA_W{1'b0}}, vec2[idx]};
  assign wr_en = WR && (state != MAC);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    idx_n   = idx;
    case (state)
      IDLE: begin
        if (Start) begin
          state_n = MAC;
          acc_n   = '0;
          idx_n   = '0;
        end
      end
      MAC: begin
        acc_n = acc + {{(ACC_W-2*DATA_W){1'b0}}, prod};
        idx_n = idx + ADDR_W'(1);
        if (idx == LAST_IDX) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      acc        <= '0;
      idx        <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      wr_ign_q   <= 1'b0;
      for (int i = 0; i < N_ELEM; i++) begin
        vec1[i] <= '0;
        vec2[i] <= '0;
      end
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      idx      <= idx_n;
      done_q   <= (state == DONE);
      wr_ign_q <= WR && (state == MAC);
      if (wr_en) begin
        vec1[Dir] <= Data_In1;
        vec2[Dir] <= Data_In2;
      end
      if (state == DONE) data_out_q <= result_n;
    end
  end

`ifdef DOT_SAT_EN
  logic sat;
  logic ovf_q;

  assign sat      = acc > ACC_W'({OUT_W{1'b1}});
  assign result_n = sat ? {OUT_W{1'b1}} : OUT_W'(acc);

  // Ovf is sticky only until the next published result
  always_ff @(posedge CLK) begin
    if (!RST_N)             ovf_q <= 1'b0;
    else if (state == DONE) ovf_q <= sat;
  end

  assign Ovf = ovf_q;
`else
  assign result_n = OUT_W'(acc);
  assign Ovf      = 1'b0;
`endif

  assign Busy     = (state != IDLE);
  assign Done     = done_q;
  assign Wr_Ign   = wr_ign_q;
  assign Data_Out = data_out_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench for dot_product_sequencer: vector table, hand sequences and random runs vs a sum model.
module tb_dot_product_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  Data_In1, Data_In2;
  logic [1:0]  Dir;
  logic        WR, Start;
  logic        Busy, Done, Wr_Ign, Ovf;
  logic [15:0] Data_Out;

  int n_cmp = 0;
  int n_err = 0;

  int unsigned mv1 [4];
  int unsigned mv2 [4];

  typedef struct {
    int unsigned a [4];
    int unsigned b [4];
    longint unsigned sum;
  } vec_t;

  vec_t tbl [9];

  dot_product_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .Data_In1(Data_In1), .Data_In2(Data_In2),
    .Dir(Dir), .WR(WR), .Start(Start), .Busy(Busy), .Done(Done),
    .Wr_Ign(Wr_Ign), .Ovf(Ovf), .Data_Out(Data_Out)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint unsigned model_sum();
    longint unsigned s = 0;
    for (int i = 0; i < 4; i++) s += longint'(mv1[i]) * longint'(mv2[i]);
    return s;
  endfunction

  function automatic void width_rule(input longint unsigned s, output logic [15:0] o, output logic v);
`ifdef DOT_SAT_EN
    if (s > 65535) begin o = 16'hFFFF; v = 1'b1; end
    else begin o = 16'(s); v = 1'b0; end
`else
    o = 16'(s);
    v = 1'b0;
`endif
  endfunction

  task automatic write_elem(input int d, input int unsigned a, input int unsigned b);
    WR = 1'b1; Dir = 2'(d); Data_In1 = 8'(a); Data_In2 = 8'(b);
    tick();
    WR = 1'b0;
    mv1[d] = a & 8'hFF;
    mv2[d] = b & 8'hFF;
  endtask

  // Start, optionally poke WR+Start during MAC, then wait (bounded) for Done and check everything.
  task automatic start_and_wait(input string nm, input longint unsigned exp_sum, input bit inject,
                                input int inj_dir, input int unsigned inj_d1, input int unsigned inj_d2);
    int cyc = 0;
    int busy_cnt;
    logic [15:0] eo;
    logic ev;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    WR = 1'b0;
    busy_cnt = Busy ? 1 : 0;
    while (!Done && cyc < 20) begin
      if (inject && cyc == 1) begin
        WR = 1'b1; Start = 1'b1;
        Dir = 2'(inj_dir); Data_In1 = 8'(inj_d1); Data_In2 = 8'(inj_d2);
      end
      tick();
      cyc++;
      if (inject && cyc == 2) begin
        WR = 1'b0; Start = 1'b0;
        check({nm, " wr_ign"}, Wr_Ign, 1);
      end
      if (Busy) busy_cnt++;
    end
    width_rule(exp_sum, eo, ev);
    check({nm, " latency"}, cyc, 5);
    check({nm, " busy_cycles"}, busy_cnt, 5);
    check({nm, " data_out"}, Data_Out, eo);
    check({nm, " ovf"}, Ovf, ev);
  endtask

  task automatic pulse_end(input string nm);
    tick();
    check({nm, " done_width"}, Done, 0);
    check({nm, " idle_after"}, Busy, 0);
  endtask

  initial begin
    logic [15:0] eo;
    logic ev;
    int dones;

    tbl[0].a = '{1, 2, 3, 4};         tbl[0].b = '{5, 6, 7, 8};         tbl[0].sum = 70;
    tbl[1].a = '{255, 255, 255, 255}; tbl[1].b = '{255, 255, 255, 255}; tbl[1].sum = 260100;
    tbl[2].a = '{0, 0, 0, 0};         tbl[2].b = '{9, 9, 9, 9};         tbl[2].sum = 0;
    tbl[3].a = '{255, 0, 255, 0};     tbl[3].b = '{255, 255, 0, 0};     tbl[3].sum = 65025;
    tbl[4].a = '{16, 16, 16, 16};     tbl[4].b = '{16, 16, 16, 16};     tbl[4].sum = 1024;
    tbl[5].a = '{200, 100, 50, 25};   tbl[5].b = '{2, 3, 4, 5};         tbl[5].sum = 1025;
    tbl[6].a = '{255, 255, 1, 1};     tbl[6].b = '{255, 255, 1, 1};     tbl[6].sum = 130052;
    tbl[7].a = '{128, 128, 128, 128}; tbl[7].b = '{128, 128, 128, 128}; tbl[7].sum = 65536;
    tbl[8].a = '{255, 255, 0, 0};     tbl[8].b = '{255, 2, 0, 0};       tbl[8].sum = 65535;

    RST_N = 1'b0; WR = 1'b0; Start = 1'b0; Dir = '0; Data_In1 = '0; Data_In2 = '0;
    for (int i = 0; i < 4; i++) begin mv1[i] = 0; mv2[i] = 0; end
    tick(); tick();
    RST_N = 1'b1;
    check("rst busy", Busy, 0);
    check("rst done", Done, 0);
    check("rst wr_ign", Wr_Ign, 0);
    check("rst ovf", Ovf, 0);
    check("rst data_out", Data_Out, 0);

    // 1: start on cleared vectors
    start_and_wait("zero", 0, 1'b0, 0, 0, 0);
    pulse_end("zero");

    // table-driven vectors
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 4; i++) write_elem(i, tbl[k].a[i], tbl[k].b[i]);
      start_and_wait($sformatf("tbl%0d", k), tbl[k].sum, 1'b0, 0, 0, 0);
      pulse_end($sformatf("tbl%0d", k));
    end

    // 4: write + second Start during MAC are rejected
    for (int i = 0; i < 4; i++) write_elem(i, i + 1, i + 5);
    start_and_wait("mac_wr", 70, 1'b1, 2, 100, 100);
    tick();
    check("mac_wr done_width", Done, 0);
    check("mac_wr start_not_queued", Busy, 0);
    start_and_wait("mac_wr again", 70, 1'b0, 0, 0, 0);
    pulse_end("mac_wr again");

    // 5: write and Start on the same edge, then back-to-back Start in the Done cycle
    WR = 1'b1; Dir = 2'd0; Data_In1 = 8'd10; Data_In2 = 8'd10;
    mv1[0] = 10; mv2[0] = 10;
    start_and_wait("same_edge", 165, 1'b0, 0, 0, 0);
    start_and_wait("back2back", 165, 1'b0, 0, 0, 0);
    pulse_end("back2back");

    // write in the DONE state does not change the published result
    Start = 1'b1; tick(); Start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("done_wr state_busy", Busy, 1);
    write_elem(3, 1, 1);
    check("done_wr done", Done, 1);
    check("done_wr data_out", Data_Out, 165);
    pulse_end("done_wr");
    start_and_wait("done_wr next", model_sum(), 1'b0, 0, 0, 0);
    pulse_end("done_wr next");

    // 6: reset in the middle of a computation
    Start = 1'b1; tick(); Start = 1'b0;
    tick();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin mv1[i] = 0; mv2[i] = 0; end
    check("abort busy", Busy, 0);
    check("abort done", Done, 0);
    check("abort data_out", Data_Out, 0);
    check("abort ovf", Ovf, 0);
    dones = 0;
    for (int c = 0; c < 8; c++) begin tick(); if (Done) dones++; end
    check("abort no_done", dones, 0);
    start_and_wait("abort restart", 0, 1'b0, 0, 0, 0);
    pulse_end("abort restart");

    // randomized runs against the sum model
    for (int r = 0; r < 30; r++) begin
      int nw = $urandom_range(0, 6);
      for (int w = 0; w < nw; w++) begin
        int unsigned a = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
        int unsigned b = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
        write_elem($urandom_range(0, 3), a, b);
      end
      start_and_wait($sformatf("rnd%0d", r), model_sum(), bit'($urandom_range(0, 1)),
                     $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
      pulse_end($sformatf("rnd%0d", r));
    end

    width_rule(model_sum(), eo, ev);
    check("final hold data_out", Data_Out, eo);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
